// File: rtl/step_seq.sv
// -----------------------------------------------------------------------------
// step_seq -- sequencer for a blocked elimination run on the "step" engine.
//
// The matrix is split into B = K/N column blocks. For each pivot block p the
// sequencer issues one phase-A (pivot/elimination) op on block p. It then
// issues phase-B (apply) ops on blocks p+1 .. B-1 in ascending order. A full
// run is B*(B+1)/2 ops. Each op is a start/done handshake with "step", and
// this block is the initiator. A watchdog aborts the run into ERROR if an op
// does not complete within TIMEOUT wait cycles.
//
// Parameters
//   N        systolic line width (column block width)
//   L        matrix row count (not used by the sequencing itself)
//   K        matrix column count, must be a multiple of N
//   TIMEOUT  wait cycles allowed per op before the watchdog fires
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-low reset
//   go          start a full run; honoured only in IDLE or ERROR
//   step_done   one-cycle completion pulse from step
//   step_start  one-cycle start pulse to step
//   col_block   column block index for the current op
//   functionA   1 = phase A (pivot/elimination), 0 = phase B (apply)
//   busy        run in progress
//   finished    one-cycle pulse after the last op completes
//   error       sticky watchdog flag, cleared by the next go
//   op_count    ops completed in the current run (saturating)
// -----------------------------------------------------------------------------
module step_seq #(
    parameter int N       = 4,
    parameter int L       = 8,
    parameter int K       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  go,
    input  logic                                  step_done,
    output logic                                  step_start,
    output logic [$clog2(K/N+1)-1:0]              col_block,
    output logic                                  functionA,
    output logic                                  busy,
    output logic                                  finished,
    output logic                                  error,
    output logic [$clog2((K/N)*(K/N+1)/2+1)-1:0]  op_count
);

    localparam int B    = K / N;
    localparam int NOPS = B * (B + 1) / 2;
    localparam int CW   = $clog2(B + 1);
    localparam int OW   = $clog2(NOPS + 1);
    localparam int WW   = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] LAST_CB = CW'(B - 1);
    localparam logic [OW-1:0] MAX_OPS = OW'(NOPS);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    generate
        if (((K % N) != 0) || (L < 1) || (TIMEOUT < 1)) begin : g_bad_params
            $error("step_seq: K must be a multiple of N, L and TIMEOUT must be positive");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        NEXT,
        ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   pivot_q, pivot_d;
    logic [WW-1:0]   wdog_q,  wdog_d;

    // Next values of the registered outputs.
    logic            start_d;
    logic [CW-1:0]   col_d;
    logic            fa_d;
    logic            busy_d;
    logic            finished_d;
    logic            error_d;
    logic [OW-1:0]   ops_d;

    // -------------------------------------------------------------------------
    // State and output registers. Every output is a flop, so the combinational
    // process below computes what each output becomes at the next edge.
    // -------------------------------------------------------------------------
    // NOTE: the reset is in the sensitivity list, so rst=0 clears every flop at
    // once without waiting for a clock edge. Sequential state uses
    // non-blocking (<=) assignments so that all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pivot_q    <= '0;
            wdog_q     <= '0;
            step_start <= 1'b0;
            col_block  <= '0;
            functionA  <= 1'b0;
            busy       <= 1'b0;
            finished   <= 1'b0;
            error      <= 1'b0;
            op_count   <= '0;
        end else begin
            state_q    <= state_d;
            pivot_q    <= pivot_d;
            wdog_q     <= wdog_d;
            step_start <= start_d;
            col_block  <= col_d;
            functionA  <= fa_d;
            busy       <= busy_d;
            finished   <= finished_d;
            error      <= error_d;
            op_count   <= ops_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic.
    // step_start and finished are pulses, so they default to 0. Everything
    // else defaults to holding its value. col_block and functionA change only
    // when entering ISSUE, which keeps them stable for the whole handshake.
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default at the top. A path that
    // skips an assignment would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        pivot_d    = pivot_q;
        wdog_d     = wdog_q;
        start_d    = 1'b0;
        finished_d = 1'b0;
        col_d      = col_block;
        fa_d       = functionA;
        busy_d     = busy;
        error_d    = error;
        ops_d      = op_count;

        case (state_q)
            // A go in ERROR restarts the run exactly as it does from IDLE.
            IDLE, ERROR: begin
                if (go) begin
                    state_d = ISSUE;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    ops_d   = '0;
                    pivot_d = '0;
                    col_d   = '0;
                    fa_d    = 1'b1;
                    wdog_d  = '0;
                end
            end

            // step_start is high during this one cycle only.
            ISSUE: begin
                state_d = WAIT;
                wdog_d  = '0;
            end

            // If done and watchdog expiry happen in the same cycle, done is
            // checked first, so the op counts as completed.
            WAIT: begin
                if (step_done) begin
                    if (op_count != MAX_OPS) begin
                        ops_d = op_count + 1'b1;
                    end
                    // Only the last pivot issues phase A on the last block.
                    if (functionA && (col_block == LAST_CB)) begin
                        state_d    = IDLE;
                        finished_d = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        state_d = NEXT;
                    end
                end else if (wdog_q >= WD_LAST) begin
                    // This is the TIMEOUT-th wait cycle without a done.
                    state_d = ERROR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    wdog_d  = wdog_q + 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            // Gap cycle. Move to the next block of the current pivot, or start
            // phase A of the next pivot when the last block has been applied.
            NEXT: begin
                state_d = ISSUE;
                start_d = 1'b1;
                if (col_block < LAST_CB) begin
                    col_d = col_block + 1'b1;
                    fa_d  = 1'b0;
                end else begin
                    pivot_d = pivot_q + 1'b1;
                    col_d   = pivot_q + 1'b1;
                    fa_d    = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_step_seq.sv
// -----------------------------------------------------------------------------
// tb_step_seq -- self-checking bench for step_seq.
// The expected op order is built from the pivot/apply rule with nested loops.
// A cycle-stepped responder returns step_done after a chosen or random
// latency. Every cycle of each handshake is checked against that list.
// -----------------------------------------------------------------------------
module tb_step_seq;

    localparam int N       = 4;
    localparam int L       = 8;
    localparam int K       = 16;
    localparam int TIMEOUT = 64;
    localparam int B       = K / N;
    localparam int NOPS    = B * (B + 1) / 2;
    localparam int CW      = $clog2(B + 1);
    localparam int OW      = $clog2(NOPS + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          go = 1'b0;
    logic          step_done = 1'b0;
    logic          step_start;
    logic [CW-1:0] col_block;
    logic          functionA;
    logic          busy;
    logic          finished;
    logic          error;
    logic [OW-1:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_fa[$];
    int exp_cb[$];

    step_seq #(
        .N       (N),
        .L       (L),
        .K       (K),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .step_done  (step_done),
        .step_start (step_start),
        .col_block  (col_block),
        .functionA  (functionA),
        .busy       (busy),
        .finished   (finished),
        .error      (error),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at time %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge. Inputs driven
    // here are taken at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Op order: phase A on pivot p, then phase B on blocks p+1 .. B-1.
    function automatic void build_model();
        exp_fa.delete();
        exp_cb.delete();
        for (int p = 0; p < B; p++) begin
            exp_fa.push_back(1);
            exp_cb.push_back(p);
            for (int c = p + 1; c < B; c++) begin
                exp_fa.push_back(0);
                exp_cb.push_back(c);
            end
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, step_start, 0);
        check({tag, "_cb"},    col_block,  0);
        check({tag, "_fa"},    functionA,  0);
        check({tag, "_busy"},  busy,       0);
        check({tag, "_fin"},   finished,   0);
        check({tag, "_err"},   error,      0);
        check({tag, "_ops"},   op_count,   0);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    // Runs a sequence that is already in its first ISSUE cycle.
    // first_lat / lat: wait cycle (1..TIMEOUT) in which done is returned,
    //   0 = random. first_lat applies to op 0 only.
    // go_op: op during which go is re-pulsed (-1 = none).
    // abort_op: op during which reset is asserted mid-wait (-1 = none).
    task automatic run_body(input int first_lat, input int lat, input int go_op, input int abort_op);
        int d;
        build_model();
        for (int op = 0; op < exp_fa.size(); op++) begin
            check("issue_start", step_start, 1);
            check("issue_fa",    functionA,  exp_fa[op]);
            check("issue_cb",    col_block,  exp_cb[op]);
            check("issue_busy",  busy,       1);
            check("issue_err",   error,      0);
            check("issue_ops",   op_count,   op);
            // A done during ISSUE must be ignored.
            step_done = ($urandom_range(0, 3) == 0);
            if (op == 0 && first_lat > 0)
                d = first_lat;
            else if (lat > 0)
                d = lat;
            else
                d = $urandom_range(1, TIMEOUT);
            if (op == abort_op)
                d = 10;
            for (int w = 1; w <= d; w++) begin
                tick();
                step_done = 1'b0;
                go = 1'b0;
                check("wait_start", step_start, 0);
                check("wait_fa",    functionA,  exp_fa[op]);
                check("wait_cb",    col_block,  exp_cb[op]);
                check("wait_ops",   op_count,   op);
                check("wait_busy",  busy,       1);
                check("wait_err",   error,      0);
                if (op == go_op && w == 1)
                    go = 1'b1;
                if (op == abort_op && w == 3) begin
                    #2 rst = 1'b0;
                    #1 check_all_zero("async_rst");
                    #3 rst = 1'b1;
                    for (int i = 0; i < 6; i++) begin
                        tick();
                        check("post_rst_start", step_start, 0);
                        check("post_rst_busy",  busy,       0);
                        check("post_rst_fin",   finished,   0);
                    end
                    return;
                end
                if (w == d)
                    step_done = 1'b1;
            end
            tick();
            step_done = 1'b0;
            go = 1'b0;
            check("done_ops", op_count, op + 1);
            check("done_err", error,    0);
            if (op == exp_fa.size() - 1) begin
                check("fin_pulse", finished,   1);
                check("fin_busy",  busy,       0);
                check("fin_start", step_start, 0);
                tick();
                check("fin_once",  finished,   0);
                // A done in IDLE must be ignored.
                step_done = 1'b1;
                tick();
                step_done = 1'b0;
                check("idle_done_ops",   op_count,   exp_fa.size());
                check("idle_done_start", step_start, 0);
                check("idle_done_busy",  busy,       0);
                tick();
                check("idle_quiet_start", step_start, 0);
            end else begin
                check("gap_start", step_start, 0);
                check("gap_fin",   finished,   0);
                check("gap_busy",  busy,       1);
                // A done during NEXT must be ignored.
                step_done = ($urandom_range(0, 1) == 1);
                tick();
                step_done = 1'b0;
            end
        end
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // done while idle after reset
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        check("idle0_ops",   op_count,   0);
        check("idle0_start", step_start, 0);
        check("idle0_busy",  busy,       0);
        tick();
        check("idle0_start2", step_start, 0);

        // fixed 20-cycle latency, then the same run with go re-pulsed in op 3
        pulse_go();
        run_body(20, 20, -1, -1);
        pulse_go();
        run_body(20, 20, 3, -1);

        // reset in the middle of op 4, then a clean run afterwards
        pulse_go();
        run_body(0, 0, -1, 4);
        pulse_go();
        run_body(0, 0, -1, -1);

        // random latencies with a random stray go
        for (int r = 0; r < 4; r++) begin
            pulse_go();
            run_body(0, 0, $urandom_range(0, NOPS - 1), -1);
        end

        // watchdog: no done after the first start
        pulse_go();
        check("to_start", step_start, 1);
        check("to_cb",    col_block,  0);
        check("to_fa",    functionA,  1);
        for (int w = 1; w <= TIMEOUT; w++) begin
            tick();
            check("to_wait_err",  error, 0);
            check("to_wait_busy", busy,  1);
        end
        tick();
        check("to_err",   error,      1);
        check("to_busy",  busy,       0);
        check("to_start0", step_start, 0);
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        check("err_done_ops",   op_count,   0);
        check("err_sticky",     error,      1);
        check("err_done_start", step_start, 0);
        tick();
        check("err_quiet_start", step_start, 0);

        // restart from ERROR; the first op is done on its last wait cycle
        pulse_go();
        run_body(TIMEOUT, 0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/step_seq.md
STEP_SEQ -- requirements
Module: step_seq

Interface
REQ-001 Parameter N, default 4: systolic line width, same meaning as in step.
REQ-002 Parameter L, default 8: matrix row count.
REQ-003 Parameter K, default 16: matrix column count; K/N = B column blocks, K divisible by N.
REQ-004 Parameter TIMEOUT, default 64: max cycles from step_start to step_done before error.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 go  input  1  request a full elimination run; sampled only in IDLE or ERROR.
REQ-008 step_done  input  1  one-cycle completion pulse from step.
REQ-009 step_start  output  1  one-cycle start pulse to step.
REQ-010 col_block  output  $clog2(K/N+1)  column block index driven to step.
REQ-011 functionA  output  1  1 = pivot/elimination pass (phase A), 0 = apply pass (phase B).
REQ-012 busy  output  1  high from go acceptance until finished or error.
REQ-013 finished  output  1  one-cycle pulse after the last operation's step_done.
REQ-014 error  output  1  sticky watchdog flag.
REQ-015 op_count  output  $clog2(B*(B+1)/2+1)  number of completed step operations in current run.

Function
REQ-016 The block SHALL act as initiator of the step start/done handshake, issuing, for pivot p = 0..B-1: one phase-A op on col_block p, then phase-B ops on col_block p+1..B-1 in ascending order.
REQ-017 Total ops per run SHALL be B*(B+1)/2 (10 for defaults).
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, NEXT, ERROR; all outputs registered.
REQ-019 IDLE: go=1 sampled -> ISSUE; busy=1, op_count=0, p=0, col_block=0, functionA=1, error cleared.
REQ-020 ISSUE: step_start=1 for exactly this one cycle -> WAIT; watchdog counter cleared.
REQ-021 col_block and functionA SHALL be stable from the ISSUE cycle through the cycle step_done is sampled.
REQ-022 WAIT: step_done=1 sampled -> op_count+1; if last op -> IDLE with finished=1 one cycle, busy=0; else -> NEXT.
REQ-023 NEXT: one gap cycle; compute next (col_block, functionA): if col_block < B-1 then col_block+1, functionA=0; else p+1, col_block=p+1, functionA=1; -> ISSUE.
REQ-024 Minimum spacing between consecutive step_start pulses SHALL be 3 cycles after step_done (WAIT sample, NEXT, ISSUE).
REQ-025 Watchdog: counter increments each WAIT cycle; reaching TIMEOUT without step_done -> ERROR, error=1, busy=0, step_start held 0.
REQ-026 step_done simultaneous with watchdog expiry SHALL count as completion (done wins).
REQ-027 step_done sampled in IDLE, ISSUE, NEXT or ERROR SHALL be ignored with no state or counter change.
REQ-028 go while busy SHALL be ignored; go in ERROR SHALL clear error and restart exactly as from IDLE.
REQ-029 Last pivot (p=B-1) SHALL issue only its phase-A op (no phase-B ops).
REQ-030 Counters SHALL never wrap; op_count saturates at B*(B+1)/2.

Reset
REQ-031 rst=0 SHALL immediately, independent of clk, force state IDLE and step_start=0, col_block=0, functionA=0, busy=0, finished=0, error=0, op_count=0, watchdog=0.
REQ-032 Reset mid-operation SHALL abandon the run; no finished pulse; first post-reset start requires new go.

Verification
REQ-033 Reset asserted mid-WAIT, op_count=4 -> all outputs 0 same cycle, no step_start until go.
REQ-034 Defaults, go pulse, step_done returned 20 cycles after each step_start -> (fA,cb) sequence (1,0)(0,1)(0,2)(0,3)(1,1)(0,2)(0,3)(1,2)(0,3)(1,3), one finished pulse, op_count=10, busy=0.
REQ-035 go re-pulsed during op 3 -> sequence and op_count unchanged vs REQ-034.
REQ-036 No step_done after first step_start -> error=1 and busy=0 exactly 64 WAIT cycles later; subsequent go -> error=0, step_start with col_block=0, functionA=1.
REQ-037 step_done pulsed in IDLE and in NEXT -> ignored, op_count unchanged, no extra step_start.
REQ-038 step_done on the 64th WAIT cycle -> treated as completion, error stays 0.
